// File: rtl/boot_pkg.sv
// Shared definitions for the boot load sequencer.
//   state_e      : FSM state encoding
//   PH_*         : slot phase numbering, mirrors the SRAM write controller
//   WE_*         : write_enable encodings driven to the SRAM write controller
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      LOAD  = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_e;

   localparam logic [1:0] PH_POP     = 2'd0;
   localparam logic [1:0] PH_SETTLE  = 2'd1;
   localparam logic [1:0] PH_WRITE   = 2'd2;
   localparam logic [1:0] PH_RELEASE = 2'd3;

   localparam logic [1:0] WE_OFF  = 2'b00;
   localparam logic [1:0] WE_LOAD = 2'b11;

endpackage

// File: rtl/boot_watchdog.sv
// Cycle watchdog for the boot load sequencer.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : count this cycle
//   expired    : high during the LIMIT-th consecutive enabled cycle, so the
//                owner reacts on the edge that ends that cycle
module boot_watchdog #(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign expired = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/boot_load_sequencer.sv
// Boot load sequencer: moves the boot image from the boot FIFO into program
// SRAM by driving the SRAM write controller, counts committed words, and
// keeps the microprocessor in reset until the image is complete.
//
// Ports:
//   boot_seq_clk_i, boot_seq_rst_n_i : clock, async active-low reset
//   start_i, bypass_i                : start pulse (IDLE only); bypass skips load
//   fifo_empty_i                     : boot FIFO empty flag
//   micro_control_o                  : 1 = loader owns SRAM, 0 = micro owns it
//   write_enable_o                   : [1] slot counter run, [0] strobe enable
//   micro_rst_n_o                    : active-low micro reset
//   boot_busy_o, boot_done_o, boot_err_o : status
//   word_count_o                     : words committed so far
//
// Optional feature macro: BOOT_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// moves the FSM to ERROR after TIMEOUT_CYCLES cycles without FIFO data.
// Without it boot_err_o is tied low and ERROR is unreachable.
module boot_load_sequencer
   import boot_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH  = 13,
   parameter int unsigned BOOT_WORDS     = 8192,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                     boot_seq_clk_i,
   input  logic                     boot_seq_rst_n_i,
   input  logic                     start_i,
   input  logic                     bypass_i,
   input  logic                     fifo_empty_i,
   output logic                     micro_control_o,
   output logic [1:0]               write_enable_o,
   output logic                     micro_rst_n_o,
   output logic                     boot_busy_o,
   output logic                     boot_done_o,
   output logic                     boot_err_o,
   output logic [ADDRESS_WIDTH:0]   word_count_o
);

   localparam logic [ADDRESS_WIDTH:0] LAST_WORD = (ADDRESS_WIDTH + 1)'(BOOT_WORDS);

   if ((BOOT_WORDS < 1) || (BOOT_WORDS > (2 ** ADDRESS_WIDTH)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("boot_load_sequencer: illegal BOOT_WORDS or TIMEOUT_CYCLES");
   end

   state_e                 state;
   logic [1:0]             phase;
   logic [ADDRESS_WIDTH:0] word_next;
   // Low for the first clock after reset release so a start pulse coinciding
   // with reset deassertion is not taken.
   logic                   armed;

   assign word_next = word_count_o + 1'b1;

`ifdef BOOT_SEQ_TIMEOUT_EN
   logic wd_expired;
   logic err_q;

   // Clearing whenever we are not in WAIT also covers the clear on entering LOAD.
   boot_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (boot_seq_clk_i),
      .rst_n   (boot_seq_rst_n_i),
      .clr     (state != WAIT),
      .en      (state == WAIT),
      .expired (wd_expired)
   );

   assign boot_err_o = err_q;
`else
   assign boot_err_o = 1'b0;
`endif

   always_ff @(posedge boot_seq_clk_i or negedge boot_seq_rst_n_i) begin
      if (!boot_seq_rst_n_i) begin
         state           <= IDLE;
         phase           <= PH_POP;
         armed           <= 1'b0;
         micro_control_o <= 1'b1;
         write_enable_o  <= WE_OFF;
         micro_rst_n_o   <= 1'b0;
         boot_busy_o     <= 1'b0;
         boot_done_o     <= 1'b0;
         word_count_o    <= '0;
`ifdef BOOT_SEQ_TIMEOUT_EN
         err_q           <= 1'b0;
`endif
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (start_i && armed) begin
                  if (bypass_i) begin
                     state           <= DONE;
                     micro_control_o <= 1'b0;
                     boot_done_o     <= 1'b1;
                  end else begin
                     state       <= WAIT;
                     boot_busy_o <= 1'b1;
                  end
               end
            end

            WAIT: begin
               if (!fifo_empty_i) begin
                  state          <= LOAD;
                  phase          <= PH_POP;
                  write_enable_o <= WE_LOAD;
               end
`ifdef BOOT_SEQ_TIMEOUT_EN
               else if (wd_expired) begin
                  state       <= ERROR;
                  boot_busy_o <= 1'b0;
                  err_q       <= 1'b1;
               end
`endif
            end

            LOAD: begin
               // Phase tracks the controller's slot counter; a begun slot
               // always runs to PH_RELEASE regardless of the FIFO flag.
               phase <= phase + 2'd1;
               if (phase == PH_RELEASE) begin
                  word_count_o <= word_next;
                  if (word_next == LAST_WORD) begin
                     state           <= DONE;
                     write_enable_o  <= WE_OFF;
                     boot_busy_o     <= 1'b0;
                     micro_control_o <= 1'b0;
                     boot_done_o     <= 1'b1;
                  end else if (fifo_empty_i) begin
                     // Dropping write_enable clears the downstream slot counter.
                     state          <= WAIT;
                     write_enable_o <= WE_OFF;
                  end
               end
            end

            DONE: begin
               // Released one cycle after ownership moved to the micro.
               micro_rst_n_o <= 1'b1;
            end

            ERROR: ;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Self-checking bench for boot_load_sequencer (BOOT_WORDS=4, plus a
// BOOT_WORDS=1 instance for the single-slot boundary).
module tb_boot_load_sequencer;

   localparam int AW = 13;
   localparam int CW = AW + 1;

   typedef struct packed {
      logic          mc;
      logic [1:0]    we;
      logic          rstn;
      logic          busy;
      logic          done;
      logic          err;
      logic [AW:0]   cnt;
   } outs_t;

   typedef struct {
      logic  start;
      logic  bypass;
      logic  empty;
      outs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, bypass = 1'b0, fifo_empty = 1'b1;

   logic          mc0, rstn0, busy0, done0, err0;
   logic [1:0]    we0;
   logic [AW:0]   cnt0;
   logic          mc1, rstn1, busy1, done1, err1;
   logic [1:0]    we1;
   logic [AW:0]   cnt1;

   int n_vec = 0;
   int n_err = 0;
   outs_t exp_q[$];
   vec_t  tbl[$];

   always #5 clk = ~clk;

   boot_load_sequencer #(.ADDRESS_WIDTH(AW), .BOOT_WORDS(4), .TIMEOUT_CYCLES(20)) u_dut (
      .boot_seq_clk_i(clk), .boot_seq_rst_n_i(rst_n), .start_i(start), .bypass_i(bypass),
      .fifo_empty_i(fifo_empty), .micro_control_o(mc0), .write_enable_o(we0),
      .micro_rst_n_o(rstn0), .boot_busy_o(busy0), .boot_done_o(done0),
      .boot_err_o(err0), .word_count_o(cnt0));

   boot_load_sequencer #(.ADDRESS_WIDTH(AW), .BOOT_WORDS(1), .TIMEOUT_CYCLES(20)) u_dut1 (
      .boot_seq_clk_i(clk), .boot_seq_rst_n_i(rst_n), .start_i(start), .bypass_i(bypass),
      .fifo_empty_i(fifo_empty), .micro_control_o(mc1), .write_enable_o(we1),
      .micro_rst_n_o(rstn1), .boot_busy_o(busy1), .boot_done_o(done1),
      .boot_err_o(err1), .word_count_o(cnt1));

   function automatic outs_t mk(logic m, logic [1:0] w, logic r, logic b, logic d, logic e, int c);
      outs_t o;
      o.mc = m; o.we = w; o.rstn = r; o.busy = b; o.done = d; o.err = e; o.cnt = CW'(c);
      return o;
   endfunction

   function automatic outs_t o_rst();            return mk(1, 2'b00, 0, 0, 0, 0, 0); endfunction
   function automatic outs_t o_wait(int c);      return mk(1, 2'b00, 0, 1, 0, 0, c); endfunction
   function automatic outs_t o_load(int c);      return mk(1, 2'b11, 0, 1, 0, 0, c); endfunction
   function automatic outs_t o_done(int c, logic r); return mk(0, 2'b00, r, 0, 1, 0, c); endfunction

   function automatic outs_t act0();
      outs_t o;
      o.mc = mc0; o.we = we0; o.rstn = rstn0; o.busy = busy0; o.done = done0; o.err = err0; o.cnt = cnt0;
      return o;
   endfunction

   function automatic outs_t act1();
      outs_t o;
      o.mc = mc1; o.we = we1; o.rstn = rstn1; o.busy = busy1; o.done = done1; o.err = err1; o.cnt = cnt1;
      return o;
   endfunction

   task automatic check(input string name, input outs_t a, input outs_t e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got mc=%b we=%b rstn=%b busy=%b done=%b err=%b cnt=%0d, need mc=%b we=%b rstn=%b busy=%b done=%b err=%b cnt=%0d",
                  name, a.mc, a.we, a.rstn, a.busy, a.done, a.err, a.cnt,
                  e.mc, e.we, e.rstn, e.busy, e.done, e.err, e.cnt);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic cyc(input string name, input logic s, input logic b, input logic e, input outs_t x);
      start = s; bypass = b; fifo_empty = e;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      check(name, act0(), exp_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; bypass = 1'b0; fifo_empty = 1'b1;
      #7;
      check("reset_state", act0(), o_rst());
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Full 4-word load, FIFO always non-empty; row k = j+1 where j counts
      // edges since LOAD was entered.
      tbl.push_back('{start: 1'b1, bypass: 1'b0, empty: 1'b0, exp: o_wait(0)});
      for (int j = 0; j < 16; j++)
         tbl.push_back('{start: 1'b0, bypass: 1'b0, empty: 1'b0, exp: o_load(j / 4)});
      tbl.push_back('{start: 1'b0, bypass: 1'b0, empty: 1'b0, exp: o_done(4, 1'b0)});
      tbl.push_back('{start: 1'b0, bypass: 1'b0, empty: 1'b0, exp: o_done(4, 1'b1)});
      tbl.push_back('{start: 1'b1, bypass: 1'b0, empty: 1'b0, exp: o_done(4, 1'b1)});
      tbl.push_back('{start: 1'b1, bypass: 1'b1, empty: 1'b0, exp: o_done(4, 1'b1)});

      // ---- reset, start coincident with reset release is ignored, full load
      do_reset();
      cyc("start_at_reset_release", 1'b1, 1'b0, 1'b0, o_rst());
      for (int k = 0; k < tbl.size(); k++) begin
         cyc($sformatf("load4_row%0d", k), tbl[k].start, tbl[k].bypass, tbl[k].empty, tbl[k].exp);
         if (k == 4) check("words1_last_phase", act1(), o_load(0));
         if (k == 5) check("words1_done", act1(), o_done(1, 1'b0));
         if (k == 6) check("words1_rst_release", act1(), o_done(1, 1'b1));
         if (k == 17) check("words1_no_overcount", act1(), o_done(1, 1'b1));
      end

      // ---- FIFO empties during phase 1 of word 2, refills 10 cycles later
      do_reset();
      cyc("gap_idle", 1'b0, 1'b0, 1'b0, o_rst());
      cyc("gap_start", 1'b1, 1'b0, 1'b0, o_wait(0));
      cyc("gap_j0", 1'b0, 1'b0, 1'b0, o_load(0));
      for (int j = 1; j <= 25; j++) begin
         outs_t x;
         logic  e;
         e = (j >= 6 && j <= 15);
         if (j < 8)       x = o_load(j / 4);
         else if (j < 16) x = o_wait(2);
         else if (j < 20) x = o_load(2);
         else if (j < 24) x = o_load(3);
         else if (j == 24) x = o_done(4, 1'b0);
         else             x = o_done(4, 1'b1);
         cyc($sformatf("gap_j%0d", j), 1'b0, 1'b0, e, x);
      end

      // ---- bypass straight to DONE
      do_reset();
      cyc("byp_idle", 1'b0, 1'b0, 1'b1, o_rst());
      cyc("byp_start", 1'b1, 1'b1, 1'b1, o_done(0, 1'b0));
      cyc("byp_rst_release", 1'b0, 1'b0, 1'b1, o_done(0, 1'b1));
      cyc("byp_restart_ignored", 1'b1, 1'b0, 1'b0, o_done(0, 1'b1));

      // ---- async reset at word_count=2, phase 2, then reload from 0
      do_reset();
      cyc("mid_idle", 1'b0, 1'b0, 1'b0, o_rst());
      cyc("mid_start", 1'b1, 1'b0, 1'b0, o_wait(0));
      for (int j = 0; j <= 10; j++)
         cyc($sformatf("mid_j%0d", j), 1'b0, 1'b0, 1'b0, o_load(j / 4));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_async_reset", act0(), o_rst());
      @(negedge clk);
      rst_n = 1'b1;
      cyc("mid_rearm", 1'b0, 1'b0, 1'b0, o_rst());
      for (int k = 0; k < tbl.size(); k++)
         cyc($sformatf("reload_row%0d", k), tbl[k].start, tbl[k].bypass, tbl[k].empty, tbl[k].exp);

`ifdef BOOT_SEQ_TIMEOUT_EN
      // ---- watchdog: 20 cycles in WAIT with FIFO empty -> ERROR
      do_reset();
      cyc("to_idle", 1'b0, 1'b0, 1'b1, o_rst());
      cyc("to_start", 1'b1, 1'b0, 1'b1, o_wait(0));
      for (int j = 1; j < 20; j++)
         cyc($sformatf("to_wait%0d", j), 1'b0, 1'b0, 1'b1, o_wait(0));
      cyc("to_error", 1'b0, 1'b0, 1'b1, mk(1, 2'b00, 0, 0, 0, 1, 0));
      cyc("to_start_ignored", 1'b1, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 0, 1, 0));
      cyc("to_error_hold", 1'b0, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 0, 1, 0));
`endif

      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: %0d expectations left, need 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/boot_load_sequencer.md
Name: boot_load_sequencer

Overview:
Sequences the bootstrap load of program SRAM from the boot FIFO into the SRAM write mux/controller.
- Generates that controller's ownership select (micro_control) and its 2-bit write_enable per 4-cycle word slot.
- Counts loaded words and holds the microprocessor in reset until the image is complete.
- Sits between the boot FIFO status flags, the SRAM write controller, and the micro reset/boot status logic.

Parameters:
ADDRESS_WIDTH, 13, SRAM address width; word counter is ADDRESS_WIDTH+1 bits.
BOOT_WORDS, 8192, number of words in the boot image; legal range 1..2**ADDRESS_WIDTH.
TIMEOUT_CYCLES, 65535, cycles with FIFO empty during load before error (used only with BOOT_SEQ_TIMEOUT_EN).

Ports:
boot_seq_clk_i  in  1  single clock.
boot_seq_rst_n_i  in  1  asynchronous, active-low reset.
start_i  in  1  one-cycle pulse; begins the boot load. Ignored unless the state is IDLE.
bypass_i  in  1  sampled with start_i; 1 = skip the load and go straight to DONE.
fifo_empty_i  in  1  boot FIFO empty flag.
micro_control_o  out  1  1 = loader owns the SRAM; 0 = micro owns it.
write_enable_o  out  2  [1] = slot counter run, [0] = write strobe enable, to the SRAM write controller.
micro_rst_n_o  out  1  active-low reset to the microprocessor.
boot_busy_o  out  1  high in WAIT or LOAD.
boot_done_o  out  1  sticky high in DONE.
boot_err_o  out  1  sticky high in ERROR.
word_count_o  out  ADDRESS_WIDTH+1  words committed so far.

Behaviour:
- All outputs are registered.
- Reset values: micro_control_o=1, write_enable_o=2'b00, micro_rst_n_o=0, boot_busy_o=0, boot_done_o=0, boot_err_o=0, word_count_o=0. State=IDLE, phase=0.
- Reset asserted mid-load returns everything to reset values immediately (asynchronously). The word count is lost; a new start_i is required.

State machine (IDLE, WAIT, LOAD, DONE, ERROR):
- IDLE: outputs hold reset values.
  - start_i=1 and bypass_i=1 -> DONE.
  - start_i=1 and bypass_i=0 -> WAIT.
- WAIT: write_enable_o=00, boot_busy_o=1.
  - fifo_empty_i=0 -> LOAD with phase=0.
- LOAD: write_enable_o=11. The internal 2-bit phase increments every cycle and mirrors the downstream slot counter (0 = FIFO pop, 1 = data settle, 2 = SRAM write strobe, 3 = strobe release).
  - At phase 3, word_count increments (one word per 4 cycles).
  - At phase 3, if the incremented count equals BOOT_WORDS -> DONE (count checked first).
  - Else if fifo_empty_i=0 at phase 3 -> stay in LOAD; phase wraps to 0 and write_enable_o stays 11 back-to-back.
  - Else -> WAIT. write_enable_o drops to 00 the next cycle, which clears the downstream slot counter.
  - fifo_empty_i at phases 0-2 is ignored; the slot always completes once begun.
- DONE: micro_control_o=0, write_enable_o=00, boot_done_o=1, boot_busy_o=0.
  - micro_rst_n_o goes to 1 exactly one cycle after micro_control_o goes to 0, so ownership switches before the micro runs.
  - Terminal until reset; start_i is ignored.
- ERROR (only reachable with the optional feature): micro_control_o=1, write_enable_o=00, micro_rst_n_o=0, boot_err_o=1. Terminal until reset.
- word_count_o never exceeds BOOT_WORDS. With BOOT_WORDS=1, a single slot goes straight to DONE.
- A start_i pulse on the same cycle reset deasserts is ignored.

Optional Feature:
Macro BOOT_SEQ_TIMEOUT_EN.
- Defined: a watchdog counter increments every cycle spent in WAIT and clears on entering LOAD. When it reaches TIMEOUT_CYCLES the FSM goes to ERROR.
- Undefined: WAIT waits indefinitely, the ERROR state is never entered, and boot_err_o is tied to 0.

Decomposition:
- Shared package boot_pkg holds:
  - state encoding IDLE=3'd0, WAIT=3'd1, LOAD=3'd2, DONE=3'd3, ERROR=3'd4;
  - phase constants PH_POP=2'd0, PH_SETTLE=2'd1, PH_WRITE=2'd2, PH_RELEASE=2'd3;
  - write_enable encodings WE_OFF=2'b00, WE_LOAD=2'b11.
- One sub-module, boot_watchdog (a counter with clear, enable and terminal flag), instantiated only under BOOT_SEQ_TIMEOUT_EN.
- FSM and word counter stay in the top module.

Test Plan:
- Reset, BOOT_WORDS=4, FIFO always non-empty, start_i pulse -> write_enable_o=11 for 16 contiguous cycles; word_count_o steps 1,2,3,4 at 4-cycle intervals; micro_control_o=0 next cycle; micro_rst_n_o=1 one cycle later; boot_done_o=1.
- FIFO goes empty during the phase 1 of word 2 and refills 10 cycles later -> slot 2 completes; write_enable_o=00 for the empty period; LOAD resumes at phase 0; final word_count_o=4.
- start_i with bypass_i=1 -> DONE on the next cycle with word_count_o=0, micro_control_o=0, then micro_rst_n_o=1.
- Assert boot_seq_rst_n_i low at word_count_o=2, phase 2 -> all outputs return to reset values asynchronously; a re-issued start_i reloads from 0.
- BOOT_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=20, FIFO empty after start_i -> ERROR after 20 cycles in WAIT; boot_err_o=1, micro_rst_n_o stays 0, and further start_i has no effect.
